// File: rtl/wb_stage_ctrl.sv
// rtl/wb_stage_ctrl.sv - MIPS writeback stage: M/W register, decode, load extract, GRF write port
// Optional lwl/lwr merge support is compiled in with `define WB_LWLR_EN.
module wb_stage_ctrl #(
  parameter int DW     = 32,
  parameter int RA_REG = 31,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             m_valid,
  input  logic [31:0]      m_ir,
  input  logic [31:0]      m_pc,
  input  logic [DW-1:0]    m_alu,
  input  logic [31:0]      m_mem,
  input  logic [DW-1:0]    m_hi,
  input  logic [DW-1:0]    m_lo,
  input  logic [DW-1:0]    m_cp0,
  input  logic [DW-1:0]    m_rt_old,
  input  logic             m_cond,
  output logic             w_valid,
  output logic [31:0]      w_pc,
  output logic [31:0]      w_ir,
  output logic             grf_we,
  output logic [4:0]       grf_waddr,
  output logic [DW-1:0]    grf_wdata,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_MOVZ = 6'h0A;
  localparam logic [5:0] F_MOVN = 6'h0B;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_e;
  typedef enum logic [2:0] {SRC_ALU, SRC_HI, SRC_LO, SRC_PC8, SRC_LOAD, SRC_CP0, SRC_RTOLD} src_e;
  typedef enum logic [2:0] {LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WL, LD_WR} ld_e;

  logic             valid_q, valid_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [DW-1:0]    alu_q, alu_d;
  logic [31:0]      mem_q, mem_d;
  logic [DW-1:0]    hi_q, hi_d;
  logic [DW-1:0]    lo_q, lo_d;
  logic [DW-1:0]    cp0_q, cp0_d;
  logic [DW-1:0]    rt_old_q, rt_old_d;
  logic             cond_q, cond_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // A stall holds every register, so grf_* keeps replaying the same write.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    mem_d     = mem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cp0_d     = cp0_q;
    rt_old_d  = rt_old_q;
    cond_d    = cond_q;
    retired_d = retired_q;
    if (en) begin
      valid_d   = m_valid & ~flush;
      pc_d      = m_pc;
      ir_d      = m_ir;
      alu_d     = m_alu;
      mem_d     = m_mem;
      hi_d      = m_hi;
      lo_d      = m_lo;
      cp0_d     = m_cp0;
      rt_old_d  = m_rt_old;
      cond_d    = m_cond;
      retired_d = retired_q + CNT_W'(valid_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      ir_q      <= '0;
      alu_q     <= '0;
      mem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cp0_q     <= '0;
      rt_old_q  <= '0;
      cond_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_q     <= alu_d;
      mem_q     <= mem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cp0_q     <= cp0_d;
      rt_old_q  <= rt_old_d;
      cond_q    <= cond_d;
      retired_q <= retired_d;
    end
  end

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       writer;
  dst_e       dst;
  src_e       src;
  ld_e        ld;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];

  always_comb begin
    writer = 1'b0;
    dst    = DST_RT;
    src    = SRC_ALU;
    ld     = LD_W;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: begin
            writer = 1'b1;
            dst    = DST_RD;
          end
          F_JALR: begin
            writer = 1'b1;
            dst    = DST_RD;
            src    = SRC_PC8;
          end
          F_MFHI: begin
            writer = 1'b1;
            dst    = DST_RD;
            src    = SRC_HI;
          end
          F_MFLO: begin
            writer = 1'b1;
            dst    = DST_RD;
            src    = SRC_LO;
          end
          F_MOVN: begin
            writer = cond_q;
            dst    = DST_RD;
            src    = SRC_RTOLD;
          end
          F_MOVZ: begin
            writer = ~cond_q;
            dst    = DST_RD;
            src    = SRC_RTOLD;
          end
          default: writer = 1'b0;
        endcase
      end
      OP_JAL: begin
        writer = 1'b1;
        dst    = DST_RA;
        src    = SRC_PC8;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        writer = 1'b1;
      end
      OP_LB: begin
        writer = 1'b1;
        src    = SRC_LOAD;
        ld     = LD_B;
      end
      OP_LBU: begin
        writer = 1'b1;
        src    = SRC_LOAD;
        ld     = LD_BU;
      end
      OP_LH: begin
        writer = 1'b1;
        src    = SRC_LOAD;
        ld     = LD_H;
      end
      OP_LHU: begin
        writer = 1'b1;
        src    = SRC_LOAD;
        ld     = LD_HU;
      end
      OP_LW: begin
        writer = 1'b1;
        src    = SRC_LOAD;
        ld     = LD_W;
      end
`ifdef WB_LWLR_EN
      OP_LWL: begin
        writer = 1'b1;
        src    = SRC_LOAD;
        ld     = LD_WL;
      end
      OP_LWR: begin
        writer = 1'b1;
        src    = SRC_LOAD;
        ld     = LD_WR;
      end
`else
      OP_LWL, OP_LWR: writer = 1'b0;
`endif
      OP_COP0: begin
        // Only mfc0 (rs=0, reserved bits clear) writes; mtc0/eret fall through.
        if (rs == 5'd0 && ir_q[10:3] == 8'd0) begin
          writer = 1'b1;
          src    = SRC_CP0;
        end
      end
      default: writer = 1'b0;
    endcase
  end

  logic [1:0]    off;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   merged;
  logic [DW-1:0] load_data;

  assign off = alu_q[1:0];

  always_comb begin
    case (off)
      2'd0:    byte_sel = mem_q[7:0];
      2'd1:    byte_sel = mem_q[15:8];
      2'd2:    byte_sel = mem_q[23:16];
      default: byte_sel = mem_q[31:24];
    endcase
    half_sel = off[1] ? mem_q[31:16] : mem_q[15:0];
    merged   = mem_q;
`ifdef WB_LWLR_EN
    // Unaligned word halves: memory bytes replace part of the old rt value.
    if (ld == LD_WL) begin
      case (off)
        2'd0:    merged = {mem_q[7:0],  rt_old_q[23:0]};
        2'd1:    merged = {mem_q[15:0], rt_old_q[15:0]};
        2'd2:    merged = {mem_q[23:0], rt_old_q[7:0]};
        default: merged = mem_q;
      endcase
    end else if (ld == LD_WR) begin
      case (off)
        2'd0:    merged = mem_q;
        2'd1:    merged = {rt_old_q[31:24], mem_q[31:8]};
        2'd2:    merged = {rt_old_q[31:16], mem_q[31:16]};
        default: merged = {rt_old_q[31:8],  mem_q[31:24]};
      endcase
    end
`endif
    case (ld)
      LD_B:    load_data = DW'($signed(byte_sel));
      LD_BU:   load_data = DW'(byte_sel);
      LD_H:    load_data = DW'($signed(half_sel));
      LD_HU:   load_data = DW'(half_sel);
      default: load_data = DW'(merged);
    endcase
  end

  always_comb begin
    case (dst)
      DST_RD:  grf_waddr = rd;
      DST_RA:  grf_waddr = 5'(RA_REG);
      default: grf_waddr = rt;
    endcase
    case (src)
      SRC_HI:    grf_wdata = hi_q;
      SRC_LO:    grf_wdata = lo_q;
      SRC_PC8:   grf_wdata = DW'(pc_q + 32'd8);
      SRC_LOAD:  grf_wdata = load_data;
      SRC_CP0:   grf_wdata = cp0_q;
      SRC_RTOLD: grf_wdata = rt_old_q;
      default:   grf_wdata = alu_q;
    endcase
  end

  assign grf_we  = valid_q & writer & (grf_waddr != 5'd0);
  assign w_valid = valid_q;
  assign w_pc    = pc_q;
  assign w_ir    = ir_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// tb/tb_wb_stage_ctrl.sv - directed and random checks of wb_stage_ctrl against a mnemonic-level model
module tb_wb_stage_ctrl;
  localparam int DW    = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, en, flush, m_valid, m_cond;
  logic [31:0]      m_ir, m_pc, m_mem;
  logic [DW-1:0]    m_alu, m_hi, m_lo, m_cp0, m_rt_old;
  logic             w_valid, grf_we;
  logic [31:0]      w_pc, w_ir;
  logic [4:0]       grf_waddr;
  logic [DW-1:0]    grf_wdata;
  logic [CNT_W-1:0] retired;

  wb_stage_ctrl #(.DW(DW), .RA_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .m_valid(m_valid),
    .m_ir(m_ir), .m_pc(m_pc), .m_alu(m_alu), .m_mem(m_mem), .m_hi(m_hi),
    .m_lo(m_lo), .m_cp0(m_cp0), .m_rt_old(m_rt_old), .m_cond(m_cond),
    .w_valid(w_valid), .w_pc(w_pc), .w_ir(w_ir), .grf_we(grf_we),
    .grf_waddr(grf_waddr), .grf_wdata(grf_wdata), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef enum int {
    M_RALU, M_JALR, M_MFHI, M_MFLO, M_MOVN, M_MOVZ, M_IALU, M_LB, M_LH, M_LW,
    M_LBU, M_LHU, M_LWL, M_LWR, M_JAL, M_MFC0, M_NONE
  } mn_t;

  typedef struct {
    mn_t         mn;
    logic        valid;
    logic [31:0] ir, pc, alu, mem, hi, lo, cp0, rt_old;
    logic        cond;
  } txn_t;

  localparam logic [5:0] RALU_F [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                         6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  localparam logic [31:0] NW_TMPL [23] = '{
    32'h08, 32'h11, 32'h13, 32'h18, 32'h19, 32'h1A, 32'h1B, 32'h01, 32'h05, 32'h3F,
    32'hA000_0000, 32'hA400_0000, 32'hAC00_0000, 32'h1000_0000, 32'h1400_0000,
    32'h1800_0000, 32'h1C00_0000, 32'h0800_0000, 32'h4080_0000, 32'h4200_0018,
    32'hFC00_0000, 32'hEC00_0000, 32'h7000_0000};
  localparam logic [31:0] NW_MASK [23] = '{
    32'h03FF_FFC0, 32'h03FF_FFC0, 32'h03FF_FFC0, 32'h03FF_FFC0, 32'h03FF_FFC0,
    32'h03FF_FFC0, 32'h03FF_FFC0, 32'h03FF_FFC0, 32'h03FF_FFC0, 32'h03FF_FFC0,
    32'h03FF_FFFF, 32'h03FF_FFFF, 32'h03FF_FFFF, 32'h03FF_FFFF, 32'h03FF_FFFF,
    32'h03FF_FFFF, 32'h03FF_FFFF, 32'h03FF_FFFF, 32'h001F_FFFF, 32'h0000_0000,
    32'h03FF_FFFF, 32'h03FF_FFFF, 32'h03FF_FFFF};

  int          checks = 0;
  int          errors = 0;
  txn_t        w_t;
  logic        exp_valid;
  logic [31:0] exp_ret;

  function automatic txn_t zero_txn();
    txn_t t;
    t = '{mn: M_RALU, valid: 1'b0, ir: 32'd0, pc: 32'd0, alu: 32'd0, mem: 32'd0,
          hi: 32'd0, lo: 32'd0, cp0: 32'd0, rt_old: 32'd0, cond: 1'b0};
    return t;
  endfunction

  function automatic txn_t gen(input mn_t mn);
    txn_t        t;
    logic [31:0] r;
    int          idx;
    r        = $urandom;
    t        = zero_txn();
    t.mn     = mn;
    t.valid  = 1'b1;
    t.pc     = $urandom & 32'hFFFF_FFFC;
    t.alu    = $urandom;
    t.mem    = $urandom;
    t.hi     = $urandom;
    t.lo     = $urandom;
    t.cp0    = $urandom;
    t.rt_old = $urandom;
    t.cond   = 1'($urandom_range(0, 1));
    case (mn)
      M_RALU: t.ir = {6'd0, r[25:6], RALU_F[$urandom_range(0, 15)]};
      M_JALR: t.ir = {6'd0, r[25:11], 5'd0, 6'h09};
      M_MFHI: t.ir = {16'd0, r[15:11], 5'd0, 6'h10};
      M_MFLO: t.ir = {16'd0, r[15:11], 5'd0, 6'h12};
      M_MOVN: t.ir = {6'd0, r[25:11], 5'd0, 6'h0B};
      M_MOVZ: t.ir = {6'd0, r[25:11], 5'd0, 6'h0A};
      M_IALU: t.ir = {3'b001, r[31:29], r[25:0]};
      M_LB:   t.ir = {6'h20, r[25:0]};
      M_LH:   t.ir = {6'h21, r[25:0]};
      M_LWL:  t.ir = {6'h22, r[25:0]};
      M_LW:   t.ir = {6'h23, r[25:0]};
      M_LBU:  t.ir = {6'h24, r[25:0]};
      M_LHU:  t.ir = {6'h25, r[25:0]};
      M_LWR:  t.ir = {6'h26, r[25:0]};
      M_JAL:  t.ir = {6'h03, r[25:0]};
      M_MFC0: t.ir = {11'h200, r[20:11], 11'd0};
      default: begin
        idx  = $urandom_range(0, 22);
        t.ir = (r & NW_MASK[idx]) | NW_TMPL[idx];
      end
    endcase
    return t;
  endfunction

  // Mnemonic-level reference: what the register file should see for a held instruction.
  function automatic void model(input txn_t t, input logic v, output logic we,
                                output logic [4:0] wa, output logic [31:0] wd);
    logic        wr;
    logic [31:0] sb, shh;
    logic [63:0] lo_mask;
    int          k;
    k   = int'(t.alu[1:0]);
    sb  = t.mem >> (8 * k);
    shh = t.mem >> (16 * (k / 2));
    wr  = 1'b1;
    wa  = t.ir[20:16];
    wd  = t.alu;
    case (t.mn)
      M_RALU: wa = t.ir[15:11];
      M_JALR: begin wa = t.ir[15:11]; wd = t.pc + 32'd8; end
      M_MFHI: begin wa = t.ir[15:11]; wd = t.hi; end
      M_MFLO: begin wa = t.ir[15:11]; wd = t.lo; end
      M_MOVN: begin wa = t.ir[15:11]; wd = t.rt_old; wr = t.cond; end
      M_MOVZ: begin wa = t.ir[15:11]; wd = t.rt_old; wr = !t.cond; end
      M_IALU: wd = t.alu;
      M_LB:   wd = {{24{sb[7]}}, sb[7:0]};
      M_LBU:  wd = {24'd0, sb[7:0]};
      M_LH:   wd = {{16{shh[15]}}, shh[15:0]};
      M_LHU:  wd = {16'd0, shh[15:0]};
      M_LW:   wd = t.mem;
`ifdef WB_LWLR_EN
      M_LWL: begin
        lo_mask = (64'd1 << (32 - 8 * (k + 1))) - 64'd1;
        wd = (t.mem << (32 - 8 * (k + 1))) | (t.rt_old & lo_mask[31:0]);
      end
      M_LWR: begin
        lo_mask = (64'd1 << (32 - 8 * k)) - 64'd1;
        wd = (t.mem >> (8 * k)) | (t.rt_old & ~lo_mask[31:0]);
      end
`else
      M_LWL, M_LWR: begin lo_mask = 64'd0; wr = 1'b0; end
`endif
      M_JAL:  begin wa = 5'd31; wd = t.pc + 32'd8; end
      M_MFC0: wd = t.cp0;
      default: wr = 1'b0;
    endcase
    we = v & wr & (wa != 5'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    model(w_t, exp_valid, we, wa, wd);
    chk({tag, "_valid"}, 32'(w_valid), 32'(exp_valid));
    chk({tag, "_pc"}, w_pc, w_t.pc);
    chk({tag, "_ir"}, w_ir, w_t.ir);
    chk({tag, "_retired"}, retired, exp_ret);
    chk({tag, "_we"}, 32'(grf_we), 32'(we));
    if (we) begin
      chk({tag, "_waddr"}, 32'(grf_waddr), 32'(wa));
      chk({tag, "_wdata"}, grf_wdata, wd);
    end
  endtask

  task automatic step(input string tag, input txn_t t, input logic e, input logic f);
    m_valid  = t.valid;
    m_ir     = t.ir;
    m_pc     = t.pc;
    m_alu    = t.alu;
    m_mem    = t.mem;
    m_hi     = t.hi;
    m_lo     = t.lo;
    m_cp0    = t.cp0;
    m_rt_old = t.rt_old;
    m_cond   = t.cond;
    en       = e;
    flush    = f;
    @(posedge clk);
    if (e) begin
      exp_ret   = exp_ret + 32'(exp_valid);
      exp_valid = t.valid & ~f;
      w_t       = t;
    end
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(w_valid), 32'd0);
    chk({tag, "_pc"}, w_pc, 32'd0);
    chk({tag, "_ir"}, w_ir, 32'd0);
    chk({tag, "_we"}, 32'(grf_we), 32'd0);
    chk({tag, "_waddr"}, 32'(grf_waddr), 32'd0);
    chk({tag, "_wdata"}, grf_wdata, 32'd0);
    chk({tag, "_retired"}, retired, 32'd0);
  endtask

  initial begin
    txn_t        t;
    logic [31:0] r0;
    reset = 1'b0;
    en = 1'b0; flush = 1'b0; m_valid = 1'b0; m_cond = 1'b0;
    m_ir = '0; m_pc = '0; m_mem = '0; m_alu = '0; m_hi = '0; m_lo = '0; m_cp0 = '0; m_rt_old = '0;
    w_t = zero_txn(); exp_valid = 1'b0; exp_ret = 32'd0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("por");
    #1 reset = 1'b0;

    t = gen(M_LB); t.ir = {6'h20, 5'd4, 5'd9, 16'h0003}; t.mem = 32'h80FF_7F01; t.alu = 32'h1003;
    step("lb", t, 1'b1, 1'b0);
    chk("lb_const", grf_wdata, 32'hFFFF_FF80);
    chk("lb_rt", 32'(grf_waddr), 32'd9);
    t.mn = M_LBU; t.ir[31:26] = 6'h24;
    step("lbu", t, 1'b1, 1'b0);
    chk("lbu_const", grf_wdata, 32'h0000_0080);

    t = gen(M_LH); t.ir = {6'h21, 5'd4, 5'd10, 16'h0002}; t.mem = 32'h8001_1234; t.alu = 32'h1002;
    step("lh", t, 1'b1, 1'b0);
    chk("lh_const", grf_wdata, 32'hFFFF_8001);
    t.mn = M_LHU; t.ir[31:26] = 6'h25;
    step("lhu", t, 1'b1, 1'b0);
    chk("lhu_const", grf_wdata, 32'h0000_8001);

    t = gen(M_JAL); t.ir = {6'h03, 26'h0000C00}; t.pc = 32'h3000;
    step("jal", t, 1'b1, 1'b0);
    chk("jal_we", 32'(grf_we), 32'd1);
    chk("jal_waddr", 32'(grf_waddr), 32'd31);
    chk("jal_wdata", grf_wdata, 32'h3008);

    t = gen(M_RALU); t.ir = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21};
    step("addu0", t, 1'b1, 1'b0);
    chk("addu_rd0_we", 32'(grf_we), 32'd0);

    t = gen(M_MOVN); t.ir = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h0B}; t.cond = 1'b0;
    step("movn", t, 1'b1, 1'b0);
    chk("movn_c0_we", 32'(grf_we), 32'd0);
    t = gen(M_MOVZ); t.ir = {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h0A}; t.cond = 1'b0; t.rt_old = 32'h55;
    step("movz", t, 1'b1, 1'b0);
    chk("movz_we", 32'(grf_we), 32'd1);
    chk("movz_waddr", 32'(grf_waddr), 32'd7);
    chk("movz_wdata", grf_wdata, 32'h55);

    t = gen(M_LWL); t.ir = {6'h22, 5'd1, 5'd8, 16'h0001}; t.alu = 32'h2001;
    t.mem = 32'hAABB_CCDD; t.rt_old = 32'h1122_3344;
    step("lwl", t, 1'b1, 1'b0);
`ifdef WB_LWLR_EN
    chk("lwl_const", grf_wdata, 32'hCCDD_3344);
`else
    chk("lwl_off_we", 32'(grf_we), 32'd0);
`endif

    t = gen(M_NONE); t.valid = 1'b0;
    step("bubble", t, 1'b1, 1'b0);
    r0 = retired;
    for (int i = 0; i < 3; i++) step("seq", gen(mn_t'($urandom_range(0, 16))), 1'b1, 1'b0);
    step("flush", gen(M_RALU), 1'b1, 1'b1);
    chk("flush_valid", 32'(w_valid), 32'd0);
    step("stall0", gen(M_RALU), 1'b0, 1'b1);
    step("stall1", gen(M_JAL), 1'b0, 1'b0);
    chk("seq_retired3", retired, r0 + 32'd3);

    for (int i = 0; i < 400; i++) begin
      t = gen(mn_t'($urandom_range(0, 16)));
      t.valid = ($urandom_range(0, 99) < 85);
      step("rand", t, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 10));
    end

    step("pre_rst", gen(M_LW), 1'b0, 1'b0);
    reset = 1'b1;
    #1 check_reset_outputs("midrst");
    w_t = zero_txn(); exp_valid = 1'b0; exp_ret = 32'd0;
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) step("post", gen(mn_t'($urandom_range(0, 16))), 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
